// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared types and constants for the lcd_ctrl image processor
package lcd_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int IMG_W  = 8;
  localparam int NPIX   = 64;

  localparam logic [2:0] PT_INIT = 3'd4;
  localparam logic [2:0] PT_MIN  = 3'd1;
  localparam logic [2:0] PT_MAX  = 3'd7;

  typedef enum logic [3:0] {
    CMD_WRITE = 4'h0,
    CMD_UP    = 4'h1,
    CMD_DOWN  = 4'h2,
    CMD_LEFT  = 4'h3,
    CMD_RIGHT = 4'h4,
    CMD_MAX   = 4'h5,
    CMD_MIN   = 4'h6,
    CMD_AVG   = 4'h7,
    CMD_ROTL  = 4'h8,
    CMD_ROTR  = 4'h9,
    CMD_MIRX  = 4'hA,
    CMD_MIRY  = 4'hB
  } cmd_e;

  typedef logic [2:0] state_t;
  localparam state_t ST_LOAD  = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_EXEC  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/lcd_block_op.sv
// rtl/lcd_block_op.sv - combinational 2x2 window operator (mirror ops only with LCD_MIRROR_EN)
module lcd_block_op
  import lcd_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [3:0]        cmd,
  output logic [DATA_W-1:0] na,
  output logic [DATA_W-1:0] nb,
  output logic [DATA_W-1:0] nc,
  output logic [DATA_W-1:0] nd
);

  logic [DATA_W-1:0] mx_ab, mx_cd, mx, mn_ab, mn_cd, mn, avg;
  logic [DATA_W+1:0] sum;

  always_comb begin
    mx_ab = (a > b) ? a : b;
    mx_cd = (c > d) ? c : d;
    mx    = (mx_ab > mx_cd) ? mx_ab : mx_cd;
    mn_ab = (a < b) ? a : b;
    mn_cd = (c < d) ? c : d;
    mn    = (mn_ab < mn_cd) ? mn_ab : mn_cd;
    sum   = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    avg   = sum[DATA_W+1:2];

    na = a;
    nb = b;
    nc = c;
    nd = d;
    case (cmd)
      CMD_MAX:  begin na = mx;  nb = mx;  nc = mx;  nd = mx;  end
      CMD_MIN:  begin na = mn;  nb = mn;  nc = mn;  nd = mn;  end
      CMD_AVG:  begin na = avg; nb = avg; nc = avg; nd = avg; end
      CMD_ROTL: begin na = b;   nb = d;   nc = a;   nd = c;   end
      CMD_ROTR: begin na = c;   nb = a;   nc = d;   nd = b;   end
`ifdef LCD_MIRROR_EN
      CMD_MIRX: begin na = c;   nb = d;   nc = a;   nd = b;   end
      CMD_MIRY: begin na = b;   nb = a;   nc = d;   nd = c;   end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - 8x8 image controller: IROM load, 2x2 window commands, IRAM dump
// Optional mirror commands A/B are enabled by defining LCD_MIRROR_EN.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IRAM_ceb,
  output logic              IRAM_web,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A,
  input  logic [DATA_W-1:0] IRAM_Q,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [2:0]        px_q, px_d, py_q, py_d;
  logic [DATA_W-1:0] buf_q [NPIX];
  logic [DATA_W-1:0] buf_d [NPIX];
  logic              irom_rd_q, irom_rd_d;
  logic [ADDR_W-1:0] irom_a_q, irom_a_d;
  logic              iram_ceb_q, iram_ceb_d, iram_web_q, iram_web_d;
  logic [DATA_W-1:0] iram_d_q, iram_d_d;
  logic [ADDR_W-1:0] iram_a_q, iram_a_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [ADDR_W-1:0] addr_a, addr_b, addr_c, addr_d;
  logic [DATA_W-1:0] na, nb, nc, nd;
  logic              unused_iram_q;

  assign unused_iram_q = ^IRAM_Q;

  assign addr_a = {py_q - 3'd1, px_q - 3'd1};
  assign addr_b = addr_a + 6'd1;
  assign addr_c = addr_a + 6'd8;
  assign addr_d = addr_a + 6'd9;

  lcd_block_op u_block_op (
    .a   (buf_q[addr_a]),
    .b   (buf_q[addr_b]),
    .c   (buf_q[addr_c]),
    .d   (buf_q[addr_d]),
    .cmd (cmd_q),
    .na  (na),
    .nb  (nb),
    .nc  (nc),
    .nd  (nd)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    px_d       = px_q;
    py_d       = py_q;
    buf_d      = buf_q;
    irom_rd_d  = 1'b0;
    irom_a_d   = '0;
    iram_ceb_d = 1'b0;
    iram_web_d = 1'b1;
    iram_d_d   = iram_d_q;
    iram_a_d   = iram_a_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        // cnt runs two ahead of the capture index because IROM_Q lags the address by one cycle
        cnt_d = cnt_q + 7'd1;
        if (cnt_q < 7'd64) begin
          irom_rd_d = 1'b1;
          irom_a_d  = cnt_q[5:0];
        end
        if (cnt_q >= 7'd2) buf_d[cnt_q[5:0] - 6'd2] = IROM_Q;
        if (cnt_q == 7'd65) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (cmd_valid) begin
          cmd_d   = cmd;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (cmd == CMD_WRITE) ? ST_WRITE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cmd_q)
          CMD_UP:    if (py_q > PT_MIN) py_d = py_q - 3'd1;
          CMD_DOWN:  if (py_q < PT_MAX) py_d = py_q + 3'd1;
          CMD_LEFT:  if (px_q > PT_MIN) px_d = px_q - 3'd1;
          CMD_RIGHT: if (px_q < PT_MAX) px_d = px_q + 3'd1;
          default: ;
        endcase
        buf_d[addr_a] = na;
        buf_d[addr_b] = nb;
        buf_d[addr_c] = nc;
        buf_d[addr_d] = nd;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_WRITE: begin
        if (cnt_q[6]) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          iram_ceb_d = 1'b1;
          iram_web_d = 1'b0;
          iram_a_d   = cnt_q[5:0];
          iram_d_d   = buf_q[cnt_q[5:0]];
          cnt_d      = cnt_q + 7'd1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      cmd_q      <= '0;
      px_q       <= PT_INIT;
      py_q       <= PT_INIT;
      irom_rd_q  <= 1'b0;
      irom_a_q   <= '0;
      iram_ceb_q <= 1'b0;
      iram_web_q <= 1'b1;
      iram_d_q   <= '0;
      iram_a_q   <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      px_q       <= px_d;
      py_q       <= py_d;
      irom_rd_q  <= irom_rd_d;
      irom_a_q   <= irom_a_d;
      iram_ceb_q <= iram_ceb_d;
      iram_web_q <= iram_web_d;
      iram_d_q   <= iram_d_d;
      iram_a_q   <= iram_a_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Pixel storage needs no reset: every reset is followed by a full reload
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign IROM_rd  = irom_rd_q;
  assign IROM_A   = irom_a_q;
  assign IRAM_ceb = iram_ceb_q;
  assign IRAM_web = iram_web_q;
  assign IRAM_D   = iram_d_q;
  assign IRAM_A   = iram_a_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl with IROM/IRAM models
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cmd = 4'h0;
  logic       cmd_valid = 1'b0;
  logic       IROM_rd, IRAM_ceb, IRAM_web, busy, done;
  logic [5:0] IROM_A, IRAM_A;
  logic [7:0] IROM_Q = 8'h00;
  logic [7:0] IRAM_D;
  logic [7:0] IRAM_Q = 8'h00;

  logic [7:0] rom  [64];
  logic [7:0] iram [64];
  logic [7:0] expi [64];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  lcd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .IROM_rd   (IROM_rd),
    .IROM_A    (IROM_A),
    .IROM_Q    (IROM_Q),
    .IRAM_ceb  (IRAM_ceb),
    .IRAM_web  (IRAM_web),
    .IRAM_D    (IRAM_D),
    .IRAM_A    (IRAM_A),
    .IRAM_Q    (IRAM_Q),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (IROM_rd) IROM_Q <= rom[IROM_A];

  always @(posedge clk) begin
    if (IRAM_ceb === 1'b1 && IRAM_web === 1'b0) begin
      iram[IRAM_A] = IRAM_D;
      wr_cnt++;
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_rom(input bit all_ff);
    for (int i = 0; i < 64; i++) begin
      rom[i]  = all_ff ? 8'hFF : 8'(i);
      expi[i] = rom[i];
    end
  endtask

  task automatic do_reset(input string tag);
    int n;
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_rstvals"},
        32'({IROM_rd, IROM_A, IRAM_ceb, IRAM_web, IRAM_D, IRAM_A, busy, done}),
        32'({1'b0, 6'd0, 1'b0, 1'b1, 8'd0, 6'd0, 1'b1, 1'b0}));
    rst = 1'b0;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) break;
      n++;
      if (n >= 200) break;
    end
    chk({tag, "_load_cycles"}, 32'(n), 32'd65);
  endtask

  task automatic send(input logic [3:0] c, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
    if (c != 4'h0) begin
      @(posedge clk);
      #1;
      chk({tag, "_busy_exec"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic do_write(input string tag, input bit hold);
    int n, np;
    for (int i = 0; i < 64; i++) iram[i] = 8'hxx;
    wr_cnt = 0;
    done_cnt = 0;
    send(4'h0, tag);
    if (hold) begin
      cmd = 4'h5;
      cmd_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_finished"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_writes"}, 32'(wr_cnt), 32'd64);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    np = 0;
    for (int i = 0; i < 64; i++) if (iram[i] !== expi[i]) np++;
    chk({tag, "_image_bad_pixels"}, 32'(np), 32'd0);
  endtask

  initial begin
    // Plain image, reset, write with cmd_valid held high during the dump
    set_rom(1'b0);
    do_reset("t1");
    do_write("t1_wr", 1'b1);

    // No-op, then Max on the centre window
    send(4'hC, "t2_nop");
    send(4'h5, "t2_max");
    expi[27] = 8'd36; expi[28] = 8'd36; expi[35] = 8'd36; expi[36] = 8'd36;
    do_write("t2_wr", 1'b0);
    chk("t2_px27", 32'(iram[27]), 32'd36);

    // Average: (27+28+35+36)/4 = 31
    set_rom(1'b0);
    do_reset("t3");
    send(4'h7, "t3_avg");
    expi[27] = 8'd31; expi[28] = 8'd31; expi[35] = 8'd31; expi[36] = 8'd31;
    do_write("t3_wr", 1'b0);

    // Rotate CW, then CCW+CW round trip
    set_rom(1'b0);
    do_reset("t4");
    send(4'h9, "t4_cw");
    expi[27] = 8'd35; expi[28] = 8'd27; expi[35] = 8'd36; expi[36] = 8'd28;
    do_write("t4_wr", 1'b0);
    chk("t4_px28", 32'(iram[28]), 32'd27);
    send(4'h8, "t4_ccw");
    send(4'h9, "t4_cw2");
    do_write("t4_wr2", 1'b0);

    // Saturating shifts to (1,1), then Max over pixels 0,1,8,9
    set_rom(1'b0);
    do_reset("t5");
    repeat (5) send(4'h1, "t5_up");
    repeat (5) send(4'h3, "t5_left");
    send(4'h5, "t5_max");
    expi[0] = 8'd9; expi[1] = 8'd9; expi[8] = 8'd9; expi[9] = 8'd9;
    do_write("t5_wr", 1'b0);

    // Mirror X
    set_rom(1'b0);
    do_reset("t6");
    send(4'hA, "t6_mirx");
`ifdef LCD_MIRROR_EN
    expi[27] = 8'd35; expi[28] = 8'd36; expi[35] = 8'd27; expi[36] = 8'd28;
`endif
    do_write("t6_wr", 1'b0);

    // Reset in the middle of a dump after moving the point
    set_rom(1'b0);
    do_reset("t7");
    send(4'h4, "t7_right");
    send(4'h4, "t7_right");
    send(4'h0, "t7_wr_abort");
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_busy_in_rst", 32'(busy), 32'd1);
    chk("t7_ceb_in_rst", 32'(IRAM_ceb), 32'd0);
    do_reset("t7_reload");
    send(4'h5, "t7_max");
    expi[27] = 8'd36; expi[28] = 8'd36; expi[35] = 8'd36; expi[36] = 8'd36;
    do_write("t7_wr", 1'b0);

    // All-0xFF image: average must not overflow
    set_rom(1'b1);
    do_reset("t8");
    send(4'h7, "t8_avg");
    do_write("t8_wr", 1'b0);
    chk("t8_px36", 32'(iram[36]), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Image-processing controller for an 8×8, 8-bit grayscale image. After reset it loads 64 pixels from the external image ROM (IROM) into an internal pixel buffer. It then executes one 4-bit command at a time on a 2×2 window. On a write command it dumps the buffer to the external image RAM (IRAM). It sits between the command source and the IROM/IRAM memory models.

## Interface
- Clocking/reset: one clock; reset is asynchronous and active-high.
- DATA_W, 8: pixel width (fixed).
- ADDR_W, 6: pixel address width, 64 pixels (fixed).
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- cmd, input, 4: command code.
- cmd_valid, input, 1: cmd is valid. The command is accepted on a rising edge where cmd_valid=1 and busy=0.
- IROM_rd, output, 1: IROM read enable.
- IROM_A, output, 6: IROM address.
- IROM_Q, input, 8: IROM data, registered; valid the cycle after IROM_rd/IROM_A.
- IRAM_ceb, output, 1: IRAM chip enable, active-high.
- IRAM_web, output, 1: IRAM write enable, active-low; 0 means write when IRAM_ceb=1.
- IRAM_D, output, 8: IRAM write data.
- IRAM_A, output, 6: IRAM address.
- IRAM_Q, input, 8: IRAM read data. Not used functionally; no read is ever issued.
- busy, output, 1: high while loading or executing; commands are ignored while high.
- done, output, 1: one-cycle pulse after an IRAM dump completes.

## Operation
- Pixel (x,y) is at address y*8+x, with x,y in 0..7.
- Operation point (px,py) has range 1..7 and resets to (4,4).
- The window is (px-1,py-1)=a, (px,py-1)=b, (px-1,py)=c, (px,py)=d.
- Command set:
  - 0 Write: dump all 64 pixels to IRAM.
  - 1 Shift up: py-1, saturating at 1.
  - 2 Shift down: py+1, saturating at 7.
  - 3 Shift left: px-1, saturating at 1.
  - 4 Shift right: px+1, saturating at 7.
  - 5 Max: all four pixels become max(a,b,c,d).
  - 6 Min: all four pixels become min(a,b,c,d).
  - 7 Average: all four pixels become floor((a+b+c+d)/4). The sum is 10 bits, truncated by >>2.
  - 8 Rotate CCW: [a b; c d] becomes [b d; a c].
  - 9 Rotate CW: [a b; c d] becomes [c a; d b].
  - A Mirror X: swap rows, [a b; c d] becomes [c d; a b].
  - B Mirror Y: swap columns, [a b; c d] becomes [b a; d c].
  - C–F: no operation, busy still pulses.
- FSM states:
  - LOAD: entered from reset.
  - IDLE: busy=0; accepts a command.
  - EXEC: one cycle for codes 1–F.
  - WRITE: 64 cycles.
  - DONE: one cycle, then IDLE.
- Reset mid-operation aborts everything. The buffer is reloaded from IROM and the point returns to (4,4).

## Timing
- Reset values:
  - IROM_rd=0, IROM_A=0.
  - IRAM_ceb=0, IRAM_web=1, IRAM_D=0, IRAM_A=0.
  - busy=1, done=0.
- LOAD:
  - Cycle k (0..63) drives IROM_rd=1, IROM_A=k.
  - IROM_Q is captured into buffer[k] in cycle k+1.
  - After address 63, IROM_rd drops.
  - busy falls on the edge after the last capture, 65 cycles after rst deasserts.
- Accept: the edge that samples cmd_valid&&!busy registers cmd and sets busy=1.
- EXEC: the buffer/point updates on the next edge, and busy returns to 0 on that same edge. This gives a 2-cycle command-to-command cadence.
- WRITE:
  - 64 consecutive cycles with IRAM_ceb=1, IRAM_web=0, IRAM_A=i, IRAM_D=buffer[i] for i=0..63.
  - Then IRAM_ceb=0, IRAM_web=1, and done=1 for exactly one cycle, with busy=0 on the same edge.
- Outputs are registered. cmd_valid held high while busy=1 is ignored.

## Configuration
- LCD_MIRROR_EN
  - Defined: codes A/B perform the mirror operations.
  - Undefined: codes A/B are no-ops with the normal one-cycle busy pulse, and the mirror datapath is not synthesized.

## Structure
- Package lcd_ctrl_pkg holds:
  - the command enum (CMD_WRITE..CMD_MIRY);
  - the FSM state enum;
  - constants IMG_W=8, NPIX=64, PT_INIT=4, PT_MIN=1, PT_MAX=7.
- One sub-module, lcd_block_op: combinational; takes a,b,c,d and cmd, returns the four new window pixels.
- The top holds the FSM, point registers, the 64×8 buffer and the memory interface.

## Test plan
Unless stated, the IROM image is pixel[i]=i.
- Reset, then Write: busy low 65 cycles after reset; IRAM[k]=k for all k; a single done pulse.
- Max then Write: addresses 27,28,35,36 all hold 36; all other addresses are unchanged.
- Average then Write: addresses 27,28,35,36 hold 31 (126/4). With all-0xFF pixels: 0xFF, no overflow.
- Rotate CW then Write: IRAM[27]=35, [28]=27, [35]=36, [36]=28. Rotate CCW then Rotate CW restores the image.
- Shift up ×5, left ×5, then Max: point saturates at (1,1); addresses 0,1,8,9 all hold 9.
- Mirror X then Write:
  - LCD_MIRROR_EN defined: [27]=35, [28]=36, [35]=27, [36]=28.
  - LCD_MIRROR_EN undefined: image unchanged.
  - Also assert rst mid-WRITE: busy stays high, reload completes, point returns to (4,4).
